pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch PC generator: issues line-aligned I-Cache requests, applies redirects and flags misaligned fetches.
// Optional macro PCF_REDIRECT_BYPASS_EN lets a redirect target drive the request in the same cycle.
module pc_fetch_unit #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter logic [31:0] START_PC    = 32'hBFC00000,
    parameter logic [4:0]  EXC_ADEL    = 5'h04
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_index_ok,
    input  logic                   stop_fetch_i,
    input  logic                   pred_valid_i,
    input  logic [31:0]            pred_pc_i,
    input  logic                   pred_dslot_i,
    input  logic                   flush_i,
    input  logic [31:0]            flush_pc_i,
    input  logic                   exc_i,
    input  logic [31:0]            exc_pc_i,
    output logic                   fetch_valid_o,
    output logic [31:0]            vaddr_o,
    output logic [31:0]            last_vaddr_o,
    output logic [FETCH_WIDTH-1:0] inst_enable_o,
    output logic                   has_exc_o,
    output logic [4:0]             exc_code_o,
    output logic                   need_dslot_o,
    output logic                   kill_o
);
    // state  | meaning
    // S_RUN  | requesting lines from cur_pc
    // S_HOLD | misaligned fetch reported; wait for a redirect
    typedef enum logic {S_RUN, S_HOLD} state_e;

    localparam int unsigned   OFS        = $clog2(FETCH_WIDTH) + 2;
    localparam logic [31:0]   LINE_BYTES = 32'(4 * FETCH_WIDTH);

    state_e                   state_q, state_d;
    logic [31:0]              cur_pc_q, cur_pc_d;
    logic                     dslot_entry_q, dslot_entry_d;
    logic                     fetch_valid_q, fetch_valid_d;
    logic [31:0]              vaddr_q, vaddr_d;
    logic [31:0]              last_vaddr_q, last_vaddr_d;
    logic [FETCH_WIDTH-1:0]   enable_q, enable_d;
    logic                     has_exc_q, has_exc_d;
    logic [4:0]               exc_code_q, exc_code_d;
    logic                     need_dslot_q, need_dslot_d;
    logic                     kill_q, kill_d;

    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic [31:0]              eff_pc;
    logic                     eff_dslot;
    logic [31:0]              line_next;
    logic                     accept;
    logic [OFS-3:0]           slot;
    logic [FETCH_WIDTH-1:0]   mask_from;
    logic [FETCH_WIDTH-1:0]   mask_only;

    assign redirect    = exc_i | flush_i;
    assign redirect_pc = exc_i ? exc_pc_i : flush_pc_i;

`ifdef PCF_REDIRECT_BYPASS_EN
    assign eff_pc    = redirect ? redirect_pc : cur_pc_q;
    assign eff_dslot = redirect ? 1'b0 : dslot_entry_q;
`else
    assign eff_pc    = cur_pc_q;
    assign eff_dslot = dslot_entry_q;
`endif

    // rst gates the request so it drops in the same cycle reset arrives
    assign inst_req  = !rst && (state_q == S_RUN) && !stop_fetch_i && (eff_pc[1:0] == 2'b00);
    assign inst_addr = {eff_pc[31:OFS], {OFS{1'b0}}};
    assign line_next = inst_addr + LINE_BYTES;
    assign accept    = inst_req & inst_index_ok;
    assign slot      = eff_pc[OFS-1:2];
    assign mask_from = {FETCH_WIDTH{1'b1}} << slot;
    assign mask_only = FETCH_WIDTH'(1) << slot;

    always_comb begin
        state_d       = state_q;
        cur_pc_d      = cur_pc_q;
        dslot_entry_d = dslot_entry_q;
        fetch_valid_d = 1'b0;
        vaddr_d       = vaddr_q;
        last_vaddr_d  = last_vaddr_q;
        enable_d      = enable_q;
        has_exc_d     = has_exc_q;
        exc_code_d    = exc_code_q;
        need_dslot_d  = need_dslot_q;
        kill_d        = redirect;

        if (accept) begin
            fetch_valid_d = 1'b1;
            last_vaddr_d  = vaddr_q;
            vaddr_d       = eff_pc;
            has_exc_d     = 1'b0;
            exc_code_d    = 5'h00;
            need_dslot_d  = pred_dslot_i & pred_valid_i & !redirect;
            enable_d      = eff_dslot ? mask_only : mask_from;
`ifdef PCF_REDIRECT_BYPASS_EN
            if (redirect) begin
                cur_pc_d      = line_next;
                dslot_entry_d = 1'b0;
            end else
`endif
            if (redirect) begin
                cur_pc_d      = redirect_pc;
                dslot_entry_d = 1'b0;
            end else if (pred_valid_i) begin
                cur_pc_d      = pred_pc_i;
                dslot_entry_d = pred_dslot_i;
            end else begin
                cur_pc_d      = line_next;
                dslot_entry_d = 1'b0;
            end
        end else if (redirect) begin
            cur_pc_d      = redirect_pc;
            dslot_entry_d = 1'b0;
            state_d       = S_RUN;
        end else if (state_q == S_RUN && cur_pc_q[1:0] != 2'b00) begin
            fetch_valid_d = 1'b1;
            last_vaddr_d  = vaddr_q;
            vaddr_d       = cur_pc_q;
            has_exc_d     = 1'b1;
            exc_code_d    = EXC_ADEL;
            enable_d      = '0;
            need_dslot_d  = 1'b0;
            state_d       = S_HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            cur_pc_q      <= START_PC;
            dslot_entry_q <= 1'b0;
            fetch_valid_q <= 1'b0;
            vaddr_q       <= START_PC;
            last_vaddr_q  <= START_PC - 32'd4;
            enable_q      <= '1;
            has_exc_q     <= 1'b0;
            exc_code_q    <= 5'h00;
            need_dslot_q  <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_pc_q      <= cur_pc_d;
            dslot_entry_q <= dslot_entry_d;
            fetch_valid_q <= fetch_valid_d;
            vaddr_q       <= vaddr_d;
            last_vaddr_q  <= last_vaddr_d;
            enable_q      <= enable_d;
            has_exc_q     <= has_exc_d;
            exc_code_q    <= exc_code_d;
            need_dslot_q  <= need_dslot_d;
            kill_q        <= kill_d;
        end
    end

    assign fetch_valid_o = fetch_valid_q;
    assign vaddr_o       = vaddr_q;
    assign last_vaddr_o  = last_vaddr_q;
    assign inst_enable_o = enable_q;
    assign has_exc_o     = has_exc_q;
    assign exc_code_o    = exc_code_q;
    assign need_dslot_o  = need_dslot_q;
    assign kill_o        = kill_q;
endmodule
